// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encoding and helpers for the scan sequencer
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_ADVANCE = 2'd3
    } scan_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter, expired while the count sits at zero
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - walks a drive x read wire matrix, settling and converting each cell
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int SW_WIRE_CNT   = 16,
    parameter int RD_WIRE_CNT   = 16,
    parameter int SETTLE_CYCLES = 100,
    parameter int ADC_TIMEOUT   = 1024
) (
    input  logic                           clk_in,
    input  logic                           rst,
    input  logic                           scan_en,
    input  logic                           adc_done,
    output logic                           adc_start,
    output logic                           pulse_sw,
    output logic                           pulse_rd,
    output logic                           frame_start,
    output logic                           frame_done,
    output logic                           busy,
    output logic                           err_timeout,
    output logic [$clog2(SW_WIRE_CNT)-1:0] sw_idx,
    output logic [$clog2(RD_WIRE_CNT)-1:0] rd_idx
);

    localparam int SW_W    = $clog2(SW_WIRE_CNT);
    localparam int RD_W    = $clog2(RD_WIRE_CNT);
    localparam int TMR_MAX = max_int(SETTLE_CYCLES, ADC_TIMEOUT);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    scan_state_t      r_state;
    logic             r_adc_start;
    logic             r_pulse_sw;
    logic             r_pulse_rd;
    logic             r_frame_start;
    logic             r_frame_done;
    logic             r_busy;
    logic             r_err_timeout;
    logic [SW_W-1:0]  r_sw_idx;
    logic [RD_W-1:0]  r_rd_idx;

    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_expired;
    logic             w_rd_last;
    logic             w_sw_last;

    assign w_rd_last = (r_rd_idx == RD_W'(RD_WIRE_CNT - 1));
    assign w_sw_last = (r_sw_idx == SW_W'(SW_WIRE_CNT - 1));

    // Timer is primed with N-1 on entry so the phase spans exactly N cycles.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = TMR_W'(SETTLE_CYCLES - 1);
        case (r_state)
            ST_IDLE, ST_ADVANCE: w_tmr_load = 1'b1;
            ST_SETTLE: begin
                w_tmr_load = w_tmr_expired;
                w_tmr_val  = TMR_W'(ADC_TIMEOUT - 1);
            end
            default: w_tmr_load = 1'b0;
        endcase
    end

    cycle_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk_in    (clk_in),
        .rst       (rst),
        .i_load    (w_tmr_load),
        .i_load_val(w_tmr_val),
        .o_expired (w_tmr_expired)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_adc_start   <= 1'b0;
            r_pulse_sw    <= 1'b0;
            r_pulse_rd    <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_sw_idx      <= '0;
            r_rd_idx      <= '0;
        end else begin
            r_adc_start   <= 1'b0;
            r_pulse_sw    <= 1'b0;
            r_pulse_rd    <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (scan_en) begin
                        r_state       <= ST_SETTLE;
                        r_frame_start <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (w_tmr_expired) begin
                        r_state     <= ST_CONVERT;
                        r_adc_start <= 1'b1;
                    end
                end
                ST_CONVERT: begin
                    // A done arriving on the expiry cycle still counts as success.
                    if (adc_done || w_tmr_expired) begin
                        if (!adc_done) begin
                            r_err_timeout <= 1'b1;
                        end
                        r_state      <= ST_ADVANCE;
                        r_pulse_rd   <= 1'b1;
                        r_pulse_sw   <= w_rd_last;
                        r_frame_done <= w_rd_last && w_sw_last;
                    end
                end
                ST_ADVANCE: begin
                    if (w_rd_last) begin
                        r_rd_idx <= '0;
                        r_sw_idx <= w_sw_last ? '0 : r_sw_idx + 1'b1;
                    end else begin
                        r_rd_idx <= r_rd_idx + 1'b1;
                    end
                    if (w_rd_last && w_sw_last && !scan_en) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state       <= ST_SETTLE;
                        r_frame_start <= w_rd_last && w_sw_last;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign adc_start   = r_adc_start;
    assign pulse_sw    = r_pulse_sw;
    assign pulse_rd    = r_pulse_rd;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign busy        = r_busy;
    assign err_timeout = r_err_timeout;
    assign sw_idx      = r_sw_idx;
    assign rd_idx      = r_rd_idx;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - randomized frame schedules checked edge by edge against a timeline model
module tb_scan_sequencer;

    localparam int SW    = 2;
    localparam int RD    = 3;
    localparam int ST    = 4;
    localparam int TO    = 8;
    localparam int MAXE  = 512;
    localparam int NRUNS = 14;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       scan_en = 1'b0;
    logic       adc_done = 1'b0;
    logic       adc_start, pulse_sw, pulse_rd, frame_start, frame_done, busy, err_timeout;
    logic [0:0] sw_idx;
    logic [1:0] rd_idx;

    always #5 clk_in = ~clk_in;

    scan_sequencer #(
        .SW_WIRE_CNT  (SW),
        .RD_WIRE_CNT  (RD),
        .SETTLE_CYCLES(ST),
        .ADC_TIMEOUT  (TO)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .scan_en    (scan_en),
        .adc_done   (adc_done),
        .adc_start  (adc_start),
        .pulse_sw   (pulse_sw),
        .pulse_rd   (pulse_rd),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .busy       (busy),
        .err_timeout(err_timeout),
        .sw_idx     (sw_idx),
        .rd_idx     (rd_idx)
    );

    // Inputs sampled at posedge e, and outputs expected just after posedge e.
    bit drv_rst [MAXE];
    bit drv_scan[MAXE];
    bit drv_done[MAXE];
    bit exp_busy[MAXE];
    bit exp_fs  [MAXE];
    bit exp_fd  [MAXE];
    bit exp_as  [MAXE];
    bit exp_psw [MAXE];
    bit exp_prd [MAXE];
    bit exp_err [MAXE];
    int exp_sw  [MAXE];
    int exp_rd  [MAXE];

    int n_checks = 0;
    int n_pass   = 0;
    int cur_run  = 0;
    int cur_edge = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s run=%0d edge=%0d got=%0d expected=%0d", tag, cur_run, cur_edge, obs, exp);
    endtask

    task automatic build_run(output int end_e);
        int s, nf, t, fs, d, len, a, drop, abort_e, err_from;
        for (int e = 0; e < MAXE; e++) begin
            drv_rst[e] = 0; drv_scan[e] = 0; drv_done[e] = 0;
            exp_busy[e] = 0; exp_fs[e] = 0; exp_fd[e] = 0; exp_as[e] = 0;
            exp_psw[e] = 0; exp_prd[e] = 0; exp_err[e] = 0; exp_sw[e] = 0; exp_rd[e] = 0;
        end
        drv_rst[0] = 1;
        s        = int'($urandom_range(1, 4));
        nf       = int'($urandom_range(1, 3));
        t        = s;
        fs       = s;
        drop     = s + 1;
        err_from = -1;
        for (int f = 0; f < nf; f++) begin
            fs = t;
            for (int sw = 0; sw < SW; sw++) begin
                for (int rd = 0; rd < RD; rd++) begin
                    // d in 1..TO: done in conversion cycle d; TO+1 means no done in time
                    d   = int'($urandom_range(1, TO + 1));
                    len = (d <= TO) ? d : TO;
                    a   = t + ST + len;
                    for (int e = t; e <= a; e++) begin
                        exp_busy[e] = 1;
                        exp_sw[e]   = sw;
                        exp_rd[e]   = rd;
                    end
                    if (sw == 0 && rd == 0) exp_fs[t] = 1;
                    exp_as[t + ST] = 1;
                    if (d <= TO) begin
                        drv_done[t + ST + d] = 1;
                    end else begin
                        drv_done[a + 1] = 1;
                        if (err_from < 0) err_from = a;
                    end
                    if ($urandom_range(0, 1) == 1) drv_done[t + int'($urandom_range(1, ST))] = 1;
                    exp_prd[a] = 1;
                    exp_psw[a] = (rd == RD - 1);
                    exp_fd[a]  = (rd == RD - 1) && (sw == SW - 1);
                    t = a + 1;
                end
            end
            if (f == nf - 1) drop = int'($urandom_range(fs + 1, t));
        end
        for (int e = s; e < drop; e++) drv_scan[e] = 1;
        if (err_from >= 0) begin
            for (int e = err_from; e < MAXE; e++) exp_err[e] = 1;
        end
        end_e = t + 4;
        if ($urandom_range(0, 2) == 0) begin
            abort_e = int'($urandom_range(s + 1, t - 1));
            drv_rst[abort_e] = 1;
            for (int e = abort_e; e < MAXE; e++) begin
                drv_scan[e] = 0;
                exp_busy[e] = 0; exp_fs[e] = 0; exp_fd[e] = 0; exp_as[e] = 0;
                exp_psw[e] = 0; exp_prd[e] = 0; exp_err[e] = 0; exp_sw[e] = 0; exp_rd[e] = 0;
            end
            end_e = abort_e + 4;
        end
    endtask

    initial begin
        int end_e;
        for (int r = 0; r < NRUNS; r++) begin
            cur_run = r;
            build_run(end_e);
            for (int e = 0; e <= end_e; e++) begin
                @(negedge clk_in);
                rst      = drv_rst[e];
                scan_en  = drv_scan[e];
                adc_done = drv_done[e];
                @(posedge clk_in);
                #1;
                cur_edge = e;
                check("busy",        int'(busy),        int'(exp_busy[e]));
                check("frame_start", int'(frame_start), int'(exp_fs[e]));
                check("frame_done",  int'(frame_done),  int'(exp_fd[e]));
                check("adc_start",   int'(adc_start),   int'(exp_as[e]));
                check("pulse_sw",    int'(pulse_sw),    int'(exp_psw[e]));
                check("pulse_rd",    int'(pulse_rd),    int'(exp_prd[e]));
                check("err_timeout", int'(err_timeout), int'(exp_err[e]));
                check("sw_idx",      int'(sw_idx),      exp_sw[e]);
                check("rd_idx",      int'(rd_idx),      exp_rd[e]);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter SW_WIRE_CNT, default 16: number of drive (switch) wires, >= 2.
REQ-002 SHALL have parameter RD_WIRE_CNT, default 16: number of read wires, >= 2.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 100: cycles the mux settles before each conversion, >= 1.
REQ-004 SHALL have parameter ADC_TIMEOUT, default 1024: maximum CONVERT cycles to wait for adc_done, >= 2.
REQ-005 SHALL have port clk_in, input, 1 bit: sole clock, all logic on posedge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port scan_en, input, 1 bit: level; high requests continuous frame scanning.
REQ-008 SHALL have port adc_done, input, 1 bit: single-cycle pulse, conversion complete.
REQ-009 SHALL have port adc_start, output, 1 bit: single-cycle conversion request.
REQ-010 SHALL have port pulse_sw, output, 1 bit: advance the drive-wire mux select.
REQ-011 SHALL have port pulse_rd, output, 1 bit: advance the read-wire mux select.
REQ-012 SHALL have ports frame_start and frame_done, output, 1 bit each: single-cycle frame markers.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port err_timeout, output, 1 bit: sticky ADC timeout flag.
REQ-015 SHALL have ports sw_idx and rd_idx, output, $clog2(SW_WIRE_CNT) and $clog2(RD_WIRE_CNT) bits: current cell, tracking the downstream mux select counters.

Function
REQ-016 SHALL implement states IDLE, SETTLE, CONVERT, ADVANCE; all outputs registered.
REQ-017 IDLE: with scan_en sampled high, SHALL enter SETTLE next cycle and assert frame_start in that first SETTLE cycle.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter CONVERT; adc_start SHALL be high only in the first CONVERT cycle.
REQ-019 CONVERT: adc_done high in any CONVERT cycle SHALL move to ADVANCE next cycle; adc_done outside CONVERT SHALL be ignored.
REQ-020 CONVERT lasting ADC_TIMEOUT cycles without adc_done SHALL set err_timeout and move to ADVANCE; adc_done in the expiry cycle wins (no error).
REQ-021 ADVANCE lasts one cycle; pulse_rd SHALL be high in it for every cell.
REQ-022 ADVANCE with rd_idx < RD_WIRE_CNT-1: rd_idx increments, pulse_sw low, next state SETTLE.
REQ-023 ADVANCE with rd_idx = RD_WIRE_CNT-1 and sw_idx < SW_WIRE_CNT-1: rd_idx wraps to 0, sw_idx increments, pulse_sw high, next SETTLE.
REQ-024 ADVANCE at last cell: both indices wrap to 0, pulse_sw high, frame_done high; next SETTLE with frame_start if scan_en high, else IDLE.
REQ-025 scan_en falling mid-frame SHALL NOT abort; the frame completes per REQ-024.
REQ-026 pulse_sw and pulse_rd SHALL each be high at most one cycle per ADVANCE, keeping the downstream wrap-on-count selects equal to sw_idx/rd_idx.
REQ-027 Counters SHALL be sized $clog2(N+1) bits for their maximum count N; no overflow at parameter extremes.

Reset
REQ-028 rst SHALL set state IDLE, sw_idx=0, rd_idx=0, err_timeout=0, and all pulse outputs and busy low on the next edge.
REQ-029 rst mid-operation SHALL suppress any pulse in that cycle; no frame_done is emitted for the aborted frame.
REQ-030 err_timeout SHALL clear only on rst.

Structure
REQ-031 Package scan_pkg SHALL hold the scan_state_t enum.
REQ-032 One sub-module cycle_timer (loadable down-counter with expiry flag) SHALL serve both settle and timeout timing.

Verification (SW=2, RD=3, SETTLE=4, TIMEOUT=8)
REQ-033 Reset, scan_en=1, adc_done 2 cycles after each adc_start -> 6 adc_start, 6 pulse_rd, 2 pulse_sw, 1 frame_done; indices 0 afterwards.
REQ-034 scan_en rising in cycle N -> frame_start at N+1, adc_start at N+5.
REQ-035 Withhold adc_done -> err_timeout at 8th CONVERT cycle, scan proceeds to the next cell, flag stays high until rst.
REQ-036 Drop scan_en at cell (0,1) -> frame completes, frame_done once, then IDLE with busy=0.
REQ-037 rst asserted during CONVERT of cell (1,2) -> next cycle IDLE, indices 0, no pulses or frame_done.
REQ-038 Spurious adc_done during SETTLE -> ignored, adc_start timing unchanged.
